fwd_hazard_unit: RTL and testbench

- Parametrised successor to the decode-stage forwarding select logic.
- Generates per-read-port bypass selects from any number of downstream producer stages, with youngest-stage priority.
- Adds a load-use interlock FSM that stalls decode for a configurable number of cycles when the EX-stage producer is a load.
- Adds flush handling and a saturating stall-event counter.
- Sits beside the decode stage; its outputs drive the decode operand muxes and the fetch/decode hold logic.

---
 rtl/fwd_hazard_unit.sv | 133 +++++++++++++
 tb/tb_fwd_hazard_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit : decode bypass selects plus load-use interlock and counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fwd_hazard_unit #(
  parameter int REG_W    = 4,
  parameter int NRD      = 2,
  parameter int NFWD     = 3,
  parameter int SEL_W    = 2,
  parameter int LOAD_LAT = 1,
  parameter int ZERO_REG = 0,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dcd_valid,
  input  logic [NRD*REG_W-1:0]  dcd_rs,
  input  logic [NRD-1:0]        dcd_rs_used,
  input  logic [NFWD-1:0]       stage_wr,
  input  logic [NFWD*REG_W-1:0] stage_rd,
  input  logic                  exe_is_load,
  input  logic                  flush,
  output logic [NRD*SEL_W-1:0]  dcd_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_events
);

  localparam int CNT_BITS = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_BITS-1:0] LAT_M1 = CNT_BITS'(LOAD_LAT - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  logic [NRD*NFWD-1:0] match;
  logic [NRD-1:0]      ex_hit;
  logic                hazard;

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_port
      logic [REG_W-1:0] rs;
      logic [SEL_W-1:0] sel;
      logic             rs_blocked;

      assign rs         = dcd_rs[p*REG_W +: REG_W];
      assign rs_blocked = (ZERO_REG != 0) && (rs == '0);

      for (genvar s = 0; s < NFWD; s++) begin : g_stage
        assign match[p*NFWD + s] = dcd_rs_used[p] & stage_wr[s] & ~rs_blocked &
                                   (rs == stage_rd[s*REG_W +: REG_W]);
      end

      // Scan oldest to youngest so the youngest matching stage overwrites.
      always_comb begin
        sel = '0;
        for (int s = NFWD - 1; s >= 0; s--) begin
          if (match[p*NFWD + s]) sel = SEL_W'(s + 1);
        end
      end

      assign dcd_sel[p*SEL_W +: SEL_W] = sel;
      assign ex_hit[p] = match[p*NFWD];
    end
  endgenerate

  assign hazard = dcd_valid & exe_is_load & (|ex_hit);

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]    events_q, events_d;
  logic                stall_int;
  logic                detect;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_int = 1'b0;
    detect    = 1'b0;
    case (state_q)
      S_IDLE: begin
        stall_int = hazard & ~flush;
        if (stall_int) begin
          detect = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = S_STALL;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_STALL: begin
        stall_int = ~flush;
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(1)) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    events_d = events_q;
    if (detect && (events_q != '1)) events_d = events_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      events_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      events_q <= events_d;
    end
  end

  // Held low while reset is asserted so a mid-stall reset drops it at once.
  assign stall        = stall_int & ~reset;
  assign stall_events = events_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_fwd_hazard_unit : directed vectors and sequences over three configurations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fwd_hazard_unit;

  logic        clk;
  logic        reset;
  logic        dcd_valid;
  logic [7:0]  dcd_rs;
  logic [1:0]  dcd_rs_used;
  logic [2:0]  stage_wr;
  logic [11:0] stage_rd;
  logic        exe_is_load;
  logic        flush;

  logic [3:0]  sel_a, sel_b, sel_c;
  logic        stall_a, stall_b, stall_c;
  logic [15:0] ev_a, ev_b;
  logic [1:0]  ev_c;

  int checks   = 0;
  int failures = 0;

  // A: defaults. B: ZERO_REG=1, LOAD_LAT=3. C: CNT_W=2.
  fwd_hazard_unit u_a (
    .clk(clk), .reset(reset), .dcd_valid(dcd_valid), .dcd_rs(dcd_rs),
    .dcd_rs_used(dcd_rs_used), .stage_wr(stage_wr), .stage_rd(stage_rd),
    .exe_is_load(exe_is_load), .flush(flush), .dcd_sel(sel_a),
    .stall(stall_a), .stall_events(ev_a)
  );

  fwd_hazard_unit #(.LOAD_LAT(3), .ZERO_REG(1)) u_b (
    .clk(clk), .reset(reset), .dcd_valid(dcd_valid), .dcd_rs(dcd_rs),
    .dcd_rs_used(dcd_rs_used), .stage_wr(stage_wr), .stage_rd(stage_rd),
    .exe_is_load(exe_is_load), .flush(flush), .dcd_sel(sel_b),
    .stall(stall_b), .stall_events(ev_b)
  );

  fwd_hazard_unit #(.CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .dcd_valid(dcd_valid), .dcd_rs(dcd_rs),
    .dcd_rs_used(dcd_rs_used), .stage_wr(stage_wr), .stage_rd(stage_rd),
    .exe_is_load(exe_is_load), .flush(flush), .dcd_sel(sel_c),
    .stall(stall_c), .stall_events(ev_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic       load;
    logic [3:0] rs0, rs1;
    logic [1:0] used;
    logic [2:0] wr;
    logic [3:0] ex, mem, wb;
    logic [1:0] a0, a1, b0, b1;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic ld, input logic [3:0] rs0,
                        input logic [3:0] rs1, input logic [1:0] used,
                        input logic [2:0] wr, input logic [3:0] ex,
                        input logic [3:0] mem, input logic [3:0] wb);
    dcd_valid   = v;
    exe_is_load = ld;
    dcd_rs      = {rs1, rs0};
    dcd_rs_used = used;
    stage_wr    = wr;
    stage_rd    = {wb, mem, ex};
  endtask

  task automatic bubble();
    exe_is_load = 1'b0;
    stage_wr    = 3'b000;
  endtask

  initial begin
    //             v     ld    rs0    rs1    used   wr      ex     mem    wb     a0    a1    b0    b1
    vecs[0]  = '{1'b1, 1'b0, 4'd3,  4'd5,  2'b11, 3'b111, 4'd3,  4'd5,  4'd5,  2'd1, 2'd2, 2'd1, 2'd2};
    vecs[1]  = '{1'b1, 1'b0, 4'd0,  4'd9,  2'b11, 3'b001, 4'd0,  4'd0,  4'd0,  2'd1, 2'd0, 2'd0, 2'd0};
    vecs[2]  = '{1'b1, 1'b0, 4'd0,  4'd0,  2'b11, 3'b111, 4'd0,  4'd0,  4'd0,  2'd1, 2'd1, 2'd0, 2'd0};
    vecs[3]  = '{1'b1, 1'b0, 4'd7,  4'd7,  2'b11, 3'b110, 4'd7,  4'd7,  4'd7,  2'd2, 2'd2, 2'd2, 2'd2};
    vecs[4]  = '{1'b1, 1'b0, 4'd7,  4'd7,  2'b11, 3'b100, 4'd7,  4'd2,  4'd7,  2'd3, 2'd3, 2'd3, 2'd3};
    vecs[5]  = '{1'b1, 1'b0, 4'd3,  4'd3,  2'b00, 3'b111, 4'd3,  4'd3,  4'd3,  2'd0, 2'd0, 2'd0, 2'd0};
    vecs[6]  = '{1'b0, 1'b1, 4'd4,  4'd4,  2'b11, 3'b111, 4'd4,  4'd4,  4'd4,  2'd1, 2'd1, 2'd1, 2'd1};
    vecs[7]  = '{1'b1, 1'b1, 4'd4,  4'd6,  2'b10, 3'b111, 4'd4,  4'd6,  4'd1,  2'd0, 2'd2, 2'd0, 2'd2};
    vecs[8]  = '{1'b1, 1'b0, 4'd15, 4'd14, 2'b11, 3'b011, 4'd15, 4'd14, 4'd15, 2'd1, 2'd2, 2'd1, 2'd2};
    vecs[9]  = '{1'b1, 1'b0, 4'd1,  4'd2,  2'b11, 3'b111, 4'd3,  4'd4,  4'd5,  2'd0, 2'd0, 2'd0, 2'd0};
    vecs[10] = '{1'b1, 1'b0, 4'd5,  4'd5,  2'b11, 3'b111, 4'd1,  4'd2,  4'd5,  2'd3, 2'd3, 2'd3, 2'd3};

    reset = 1'b1;
    flush = 1'b0;
    set_in(1'b0, 1'b0, 4'd0, 4'd0, 2'b00, 3'b000, 4'd0, 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_stall_a", 32'(stall_a), 32'd0);
    chk("rst_stall_b", 32'(stall_b), 32'd0);
    chk("rst_ev_a", 32'(ev_a), 32'd0);
    chk("rst_ev_c", 32'(ev_c), 32'd0);
    reset = 1'b0;

    // Combinational select table; no vector forms a load-use hazard.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_in(vecs[i].valid, vecs[i].load, vecs[i].rs0, vecs[i].rs1, vecs[i].used,
             vecs[i].wr, vecs[i].ex, vecs[i].mem, vecs[i].wb);
      #2;
      chk($sformatf("v%0d_sel_a0", i), 32'(sel_a[1:0]), 32'(vecs[i].a0));
      chk($sformatf("v%0d_sel_a1", i), 32'(sel_a[3:2]), 32'(vecs[i].a1));
      chk($sformatf("v%0d_sel_b0", i), 32'(sel_b[1:0]), 32'(vecs[i].b0));
      chk($sformatf("v%0d_sel_b1", i), 32'(sel_b[3:2]), 32'(vecs[i].b1));
      chk($sformatf("v%0d_stall_a", i), 32'(stall_a), 32'd0);
      chk($sformatf("v%0d_stall_b", i), 32'(stall_b), 32'd0);
    end
    chk("tbl_ev_a", 32'(ev_a), 32'd0);
    chk("tbl_ev_b", 32'(ev_b), 32'd0);

    // Load-use on port1: B stalls three cycles, A and C one.
    @(negedge clk);
    set_in(1'b1, 1'b1, 4'd0, 4'd7, 2'b10, 3'b001, 4'd7, 4'd0, 4'd0);
    #2;
    chk("s1_stall_a", 32'(stall_a), 32'd1);
    chk("s1_stall_b", 32'(stall_b), 32'd1);
    chk("s1_stall_c", 32'(stall_c), 32'd1);
    chk("s1_sel_b1", 32'(sel_b[3:2]), 32'd1);
    @(negedge clk);
    bubble();
    #2;
    chk("s1c2_stall_a", 32'(stall_a), 32'd0);
    chk("s1c2_stall_b", 32'(stall_b), 32'd1);
    chk("s1_ev_a", 32'(ev_a), 32'd1);
    chk("s1_ev_b", 32'(ev_b), 32'd1);
    chk("s1_ev_c", 32'(ev_c), 32'd1);
    @(negedge clk); #2;
    chk("s1c3_stall_b", 32'(stall_b), 32'd1);
    @(negedge clk); #2;
    chk("s1c4_stall_b", 32'(stall_b), 32'd0);

    // Flush in the second stall cycle of B.
    @(negedge clk);
    set_in(1'b1, 1'b1, 4'd0, 4'd7, 2'b10, 3'b001, 4'd7, 4'd0, 4'd0);
    #2;
    chk("s2_stall_b", 32'(stall_b), 32'd1);
    @(negedge clk);
    bubble();
    flush = 1'b1;
    #2;
    chk("s2_flush_stall_b", 32'(stall_b), 32'd0);
    chk("s2_ev_b", 32'(ev_b), 32'd2);
    @(negedge clk);
    flush = 1'b0;
    #2;
    chk("s2_idle_stall_b", 32'(stall_b), 32'd0);

    // Flush coinciding with detection: no stall, no count.
    @(negedge clk);
    set_in(1'b1, 1'b1, 4'd0, 4'd7, 2'b10, 3'b001, 4'd7, 4'd0, 4'd0);
    flush = 1'b1;
    #2;
    chk("s2f_stall_a", 32'(stall_a), 32'd0);
    chk("s2f_stall_b", 32'(stall_b), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    bubble();
    #2;
    chk("s2f_ev_a", 32'(ev_a), 32'd2);
    chk("s2f_ev_b", 32'(ev_b), 32'd2);
    chk("s2f_ev_c", 32'(ev_c), 32'd2);
    chk("s2f_stall_b", 32'(stall_b), 32'd0);

    // Back-to-back loads; first one reads the same register on both ports.
    @(negedge clk);
    set_in(1'b1, 1'b1, 4'd9, 4'd9, 2'b11, 3'b001, 4'd9, 4'd0, 4'd0);
    #2;
    chk("s3_stall_a", 32'(stall_a), 32'd1);
    chk("s3_sel_a", 32'(sel_a), 32'h5);
    @(negedge clk);
    set_in(1'b1, 1'b1, 4'd2, 4'd8, 2'b11, 3'b011, 4'd2, 4'd9, 4'd0);
    #2;
    chk("s3c2_stall_a", 32'(stall_a), 32'd1);
    chk("s3c2_stall_b", 32'(stall_b), 32'd1);
    chk("s3c2_ev_a", 32'(ev_a), 32'd3);
    chk("s3c2_ev_c", 32'(ev_c), 32'd3);
    @(negedge clk);
    bubble();
    #2;
    chk("s3c3_stall_a", 32'(stall_a), 32'd0);
    chk("s3c3_stall_b", 32'(stall_b), 32'd1);
    chk("s3_ev_a", 32'(ev_a), 32'd4);
    chk("s3_ev_b", 32'(ev_b), 32'd3);
    chk("s3_ev_c_sat", 32'(ev_c), 32'd3);
    @(negedge clk); #2;
    chk("s3c4_stall_b", 32'(stall_b), 32'd0);

    // One more hazard, then reset while B is mid-stall.
    @(negedge clk);
    set_in(1'b1, 1'b1, 4'd0, 4'd7, 2'b10, 3'b001, 4'd7, 4'd0, 4'd0);
    #2;
    chk("s4_stall_c", 32'(stall_c), 32'd1);
    @(negedge clk);
    bubble();
    #2;
    chk("s4_ev_c_sat", 32'(ev_c), 32'd3);
    chk("s4_ev_a", 32'(ev_a), 32'd5);
    chk("s4_ev_b", 32'(ev_b), 32'd4);
    chk("s4_stall_b", 32'(stall_b), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("s4_rst_stall_b", 32'(stall_b), 32'd0);
    chk("s4_rst_ev_a", 32'(ev_a), 32'd0);
    chk("s4_rst_ev_b", 32'(ev_b), 32'd0);
    chk("s4_rst_ev_c", 32'(ev_c), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #2;
    chk("s4_post_stall_b", 32'(stall_b), 32'd0);
    @(negedge clk);
    set_in(1'b1, 1'b1, 4'd0, 4'd7, 2'b10, 3'b001, 4'd7, 4'd0, 4'd0);
    #2;
    chk("s4_new_stall_b", 32'(stall_b), 32'd1);
    @(negedge clk);
    bubble();
    #2;
    chk("s4_new_ev_b", 32'(ev_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
